// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/NOT, optional XOR) among NREQ requesters.
// Define LOGIC_OP_ARBITER_XOR_EN to make opcode 11 compute XOR; otherwise it returns zero with out_err set.
module logic_op_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_in1,
  input  logic [WIDTH*NREQ-1:0]   req_in2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [IDW-1:0]          out_id,
  output logic                    out_err,
  output logic                    busy
);

  localparam int unsigned OPW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   id_q;
  logic             found;
  logic             accept;
  logic             complete;
  logic [OPW-1:0]   op_q;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;
  logic [WIDTH-1:0] sel_in1;
  logic [WIDTH-1:0] sel_in2;
  logic [WIDTH-1:0] result;
  logic             result_err;
  int unsigned      pos;

  // First valid requester at or above rr_ptr, wrapping at NREQ-1
  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req_valid[IDW'(pos)]) begin
        found = 1'b1;
        win   = IDW'(pos);
      end
    end
  end

  // Payload of the current winner
  always_comb begin
    sel_op  = '0;
    sel_in1 = '0;
    sel_in2 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_op  = req_op[OPW*i +: OPW];
        sel_in1 = req_in1[WIDTH*i +: WIDTH];
        sel_in2 = req_in2[WIDTH*i +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Grants only in IDLE; a completion cycle never grants, so the next grant waits for IDLE
  always_comb begin
    next_state = state;
    req_ready  = '0;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (found && !rst) begin
          req_ready[win] = 1'b1;
          accept         = 1'b1;
          next_state     = EXEC;
        end
      end
      EXEC: next_state = RESP;
      RESP: begin
        if (out_valid && out_ready) begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Shared gate datapath
  always_comb begin
    result     = '0;
    result_err = 1'b0;
    case (op_q)
      2'b00: result = in1_q & in2_q;
      2'b01: result = in1_q | in2_q;
      2'b10: result = ~in1_q;
      2'b11: begin
`ifdef LOGIC_OP_ARBITER_XOR_EN
        result = in1_q ^ in2_q;
`else
        result_err = 1'b1;
`endif
      end
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      id_q      <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= sel_op;
        in1_q <= sel_in1;
        in2_q <= sel_in2;
        id_q  <= win;
        busy  <= 1'b1;
      end
      if (state == EXEC) begin
        out_data  <= result;
        out_id    <= id_q;
        out_err   <= result_err;
        out_valid <= 1'b1;
      end
      // Pointer moves past the winner only once its result is consumed
      if (complete) begin
        out_valid <= 1'b0;
        busy      <= 1'b0;
        rr_ptr    <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter (4 requesters, 8-bit operands); honours LOGIC_OP_ARBITER_XOR_EN.
module tb_logic_op_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_in1;
  logic [31:0] req_in2;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_err;
  logic        busy;

  int checks;
  int failures;

  logic_op_arbiter #(.NREQ(4), .WIDTH(8), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid[i]       = 1'b1;
    req_op[2*i +: 2]   = op;
    req_in1[8*i +: 8]  = a;
    req_in2[8*i +: 8]  = b;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_in1 = '0; req_in2 = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_id, out_err, busy, req_ready} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b data=%h id=%0d err=%b busy=%b ready=%b exp all zero",
               out_valid, out_data, out_id, out_err, busy, req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    set_req(2, 2'b00, 8'hF0, 8'h3C);
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || req_ready !== 4'b0000) begin
      failures++; $display("FAIL single_exec got busy=%b valid=%b ready=%b exp 1 0 0000", busy, out_valid, req_ready);
    end
    req_valid[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h30 || out_id !== 2'd2 || out_err !== 1'b0) begin
      failures++; $display("FAIL single_result got valid=%b data=%h id=%0d err=%b exp 1 30 2 0", out_valid, out_data, out_id, out_err);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_done got valid=%b busy=%b exp 0 0", out_valid, busy);
    end
  endtask

  task automatic test_opcodes;
    logic [1:0] ops  [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
    logic [7:0] in2s [4] = '{8'h0F, 8'h0F, 8'hFF, 8'h0F};
    logic [7:0] exps [4];
    logic       errs [4];
    exps[0] = 8'hAF; errs[0] = 1'b0;
    exps[1] = 8'h5A; errs[1] = 1'b0;
    exps[2] = 8'h5A; errs[2] = 1'b0;
`ifdef LOGIC_OP_ARBITER_XOR_EN
    exps[3] = 8'hAA; errs[3] = 1'b0;
`else
    exps[3] = 8'h00; errs[3] = 1'b1;
`endif
    for (int v = 0; v < 4; v++) begin
      set_req(0, ops[v], 8'hA5, in2s[v]);
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL op%0d_ready got=%b exp=0001", v, req_ready); end
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exps[v] || out_err !== errs[v] || out_id !== 2'd0) begin
        failures++; $display("FAIL op%0d_result got valid=%b data=%h err=%b id=%0d exp 1 %h %b 0",
                             v, out_valid, out_data, out_err, out_id, exps[v], errs[v]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin;
    int exp_ids [6] = '{0, 1, 2, 3, 0, 1};
    int ids [6];
    int n = 0;
    int last = 0;
    logic [3:0] m1, m2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 8'(16*i + 5), 8'hFF);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ids[n] = int'(out_id);
        checks++;
        if (int'(out_id) != exp_ids[n] || out_data !== 8'(16*exp_ids[n] + 5)) begin
          failures++; $display("FAIL rr_order%0d got id=%0d data=%h exp id=%0d data=%h",
                               n, out_id, out_data, exp_ids[n], 8'(16*exp_ids[n] + 5));
        end
        if (n > 0) begin
          checks++;
          if (c - last != 3) begin failures++; $display("FAIL rr_spacing%0d got=%0d exp=3", n, c - last); end
        end
        last = c;
        n++;
      end
    end
    checks++;
    if (n != 6) begin failures++; $display("FAIL rr_count got=%0d exp=6", n); n = 6; end
    m1 = '0; m2 = '0;
    for (int j = 0; j < 4; j++) begin
      m1[ids[j][1:0]] = 1'b1;
      m2[ids[j+2][1:0]] = 1'b1;
    end
    checks++;
    if (m1 !== 4'hF || m2 !== 4'hF) begin failures++; $display("FAIL rr_window got=%b,%b exp=1111,1111", m1, m2); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int t = 0;
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && t < 10) begin @(negedge clk); t++; end
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 8'h25) begin
      failures++; $display("FAIL bp_first got valid=%b id=%0d data=%h exp 1 2 25", out_valid, out_id, out_data);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 8'h25 || req_ready !== 4'b0000) begin
        failures++; $display("FAIL bp_hold%0d got valid=%b id=%0d data=%h ready=%b exp 1 2 25 0000",
                             k, out_valid, out_id, out_data, req_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || req_ready !== 4'b0000) begin
      failures++; $display("FAIL bp_release got valid=%b ready=%b exp 1 0000", out_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_complete got valid=%b busy=%b exp 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_exec_state got busy=%b valid=%b exp 1 0", busy, out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, out_id, out_err, busy, req_ready} !== 16'h0) begin
      failures++; $display("FAIL midrst_exec got valid=%b data=%h id=%0d err=%b busy=%b ready=%b exp all zero",
                           out_valid, out_data, out_id, out_err, busy, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h05) begin
      failures++; $display("FAIL midrst_resp_state got valid=%b data=%h exp 1 05", out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, out_id, out_err, busy, req_ready} !== 16'h0) begin
      failures++; $display("FAIL midrst_resp got valid=%b data=%h id=%0d err=%b busy=%b ready=%b exp all zero",
                           out_valid, out_data, out_id, out_err, busy, req_ready);
    end
    req_valid = 4'b1010;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL midrst_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 8'h15) begin
      failures++; $display("FAIL midrst_result got valid=%b id=%0d data=%h exp 1 1 15", out_valid, out_id, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_withdrawn;
    logic seen = 1'b0;
    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    set_req(1, 2'b01, 8'h12, 8'h40);
    set_req(3, 2'b00, 8'hFF, 8'hFF);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL wd_grant1 got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 8'h52) begin
      failures++; $display("FAIL wd_result1 got valid=%b id=%0d data=%h exp 1 1 52", out_valid, out_id, out_data);
    end
    req_valid[3] = 1'b0;
    set_req(0, 2'b10, 8'h3C, 8'h55);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 4'b0001) begin
      failures++; $display("FAIL wd_grant0 got valid=%b ready=%b exp 0 0001", out_valid, req_ready);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 8'hC3) begin
      failures++; $display("FAIL wd_result0 got valid=%b id=%0d data=%h exp 1 0 c3", out_valid, out_id, out_data);
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL wd_no_extra got result_seen=%b exp=0", seen); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_opcodes();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_withdrawn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
